ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter for the ZX81 board. It is the sending counterpart of the existing PS/2 keyboard receiver and shares the same `usb_fpga_bd_dp`/`usb_fpga_bd_dn` lines. It sends single command bytes to the keyboard, such as 0xED for set-LEDs or 0xFF for reset, using the standard PS/2 open-collector request-to-send sequence, and it checks the device acknowledge. `busy` is routed to the receiver so that the receiver ignores bus activity while a transmit is in progress.

---
 rtl/ps2_host_tx.sv | 184 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, bit shifting on device clock,
// acknowledge check and frame timeout. Outputs drive open-collector enables.
module ps2_host_tx #(
  parameter int CLK_HZ     = 12500000,
  parameter int INHIBIT_US = 120,
  parameter int TIMEOUT_MS = 20
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       done,
  output logic       error,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam longint INHIBIT_L      = (longint'(CLK_HZ) * longint'(INHIBIT_US)) / 64'sd1000000;
  localparam int     INHIBIT_CYCLES = int'(INHIBIT_L);
  localparam int     TIMEOUT_CYCLES = (CLK_HZ / 1000) * TIMEOUT_MS;
  localparam int     MAX_CYCLES     = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int     CNT_W          = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] INHIBIT_LOAD = CNT_W'(INHIBIT_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       r_idx;
  logic [3:0]       w_idx_nxt;
  logic [9:0]       r_frame;
  logic [9:0]       w_frame_nxt;
  logic             r_clk_oe;
  logic             w_clk_oe_nxt;
  logic             r_data_oe;
  logic             w_data_oe_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_error;
  logic             w_error_nxt;

  logic r_clk_s1;
  logic r_clk_sync;
  logic r_clk_prev;
  logic r_dat_s1;
  logic r_dat_sync;
  logic w_fall;
  logic w_timeout;

  assign w_fall    = r_clk_prev & ~r_clk_sync;
  // Counter is about to reach zero on this edge: the frame has used its whole budget.
  assign w_timeout = (r_cnt <= CNT_ONE);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_clk_s1   <= 1'b1;
      r_clk_sync <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_sync <= 1'b1;
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_frame    <= '0;
      r_clk_oe   <= 1'b0;
      r_data_oe  <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_clk_s1   <= ps2_clk_in;
      r_clk_sync <= r_clk_s1;
      r_clk_prev <= r_clk_sync;
      r_dat_s1   <= ps2_data_in;
      r_dat_sync <= r_dat_s1;
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_frame    <= w_frame_nxt;
      r_clk_oe   <= w_clk_oe_nxt;
      r_data_oe  <= w_data_oe_nxt;
      r_done     <= w_done_nxt;
      r_error    <= w_error_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_idx_nxt     = r_idx;
    w_frame_nxt   = r_frame;
    w_clk_oe_nxt  = r_clk_oe;
    w_data_oe_nxt = r_data_oe;
    w_done_nxt    = 1'b0;
    w_error_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_clk_oe_nxt  = 1'b0;
        w_data_oe_nxt = 1'b0;
        if (tx_valid) begin
          w_frame_nxt  = {1'b1, ~^tx_data, tx_data};
          w_clk_oe_nxt = 1'b1;
          w_cnt_nxt    = INHIBIT_LOAD;
          w_state_nxt  = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (r_cnt == '0) begin
          w_data_oe_nxt = 1'b1;
          w_clk_oe_nxt  = 1'b0;
          w_cnt_nxt     = TIMEOUT_LOAD;
          w_idx_nxt     = '0;
          w_state_nxt   = S_SHIFT;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end

      S_SHIFT, S_ACK, S_WAIT_IDLE: begin
        if (w_timeout) begin
          w_cnt_nxt     = '0;
          w_error_nxt   = 1'b1;
          w_clk_oe_nxt  = 1'b0;
          w_data_oe_nxt = 1'b0;
          w_state_nxt   = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
          if (r_state == S_SHIFT) begin
            if (w_fall) begin
              w_data_oe_nxt = ~r_frame[r_idx];
              w_idx_nxt     = r_idx + 4'd1;
              if (r_idx == 4'd9) w_state_nxt = S_ACK;
            end
          end else if (r_state == S_ACK) begin
            w_data_oe_nxt = 1'b0;
            if (w_fall) begin
              if (!r_dat_sync) begin
                w_state_nxt = S_WAIT_IDLE;
              end else begin
                w_error_nxt = 1'b1;
                w_state_nxt = S_IDLE;
              end
            end
          end else begin
            if (r_clk_sync && r_dat_sync) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end
        end
      end

      default: begin
        w_clk_oe_nxt  = 1'b0;
        w_data_oe_nxt = 1'b0;
        w_state_nxt   = S_IDLE;
      end
    endcase
  end

  assign tx_ready    = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign error       = r_error;
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector bus, device model at 12.5 kHz,
// frame/status scoreboard fed from a byte-level reference model.
module tb_ps2_host_tx;

  localparam int CLK_HZ     = 1000000;
  localparam int INHIBIT_US = 120;
  localparam int TIMEOUT_MS = 2;
  localparam int INH_EXP    = 121;
  localparam int TO_EXP     = 2000;
  localparam int HALF       = 20;

  localparam int M_ACK   = 0;
  localparam int M_NOACK = 1;
  localparam int M_NOCLK = 2;
  localparam int M_RST   = 3;

  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, done, error, busy;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low, dev_data_low;
  logic       ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .CLK_HZ(CLK_HZ),
    .INHIBIT_US(INHIBIT_US),
    .TIMEOUT_MS(TIMEOUT_MS)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .done(done),
    .error(error),
    .busy(busy),
    .ps2_clk_in(ps2_clk_line),
    .ps2_data_in(ps2_data_line),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #500 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc = cyc + 1;

  int vectors = 0;
  int misc = 0;

  logic [10:0] exp_frame[$];
  int          exp_status[$];

  int status_count = 0;
  int stat_cyc = 0;
  int rel_cyc = 0;
  int rise_cyc = 0;
  int inh_len = 0;
  logic prev_coe = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      misc++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic [10:0] f;
    int v;
    int ones;
    v = int'(d);
    ones = 0;
    f = '0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = ((v >> i) & 1) == 1;
      ones += (v >> i) & 1;
    end
    f[9]  = (ones % 2) == 0;
    f[10] = 1'b1;
    return f;
  endfunction

  // Status monitor: every done/error pulse is matched against the next expected outcome.
  always @(negedge clk_sys) begin
    int kind;
    int e;
    if (!reset && (done || error)) begin
      status_count++;
      stat_cyc = cyc;
      kind = done ? ST_DONE : ST_ERR;
      if (exp_status.size() == 0) begin
        vectors++;
        misc++;
        $display("FAIL status_unexpected: got %0d expected none at cycle %0d", kind, cyc);
      end else begin
        e = exp_status.pop_front();
        check("status_kind", 32'(kind), 32'(e));
      end
      check("pulse_exclusive", 32'(done & error), 32'd0);
      check("idle_after_pulse", 32'({busy, tx_ready, ps2_clk_oe, ps2_data_oe}), 32'b0100);
    end
  end

  // Inhibit monitor: clock hold length and start bit coinciding with release.
  always @(negedge clk_sys) begin
    if (ps2_clk_oe && !prev_coe) begin
      rise_cyc = cyc;
      inh_len = 0;
    end
    if (ps2_clk_oe) inh_len++;
    if (!ps2_clk_oe && prev_coe) begin
      rel_cyc = cyc;
      check("inhibit_len", 32'(inh_len), 32'(INH_EXP));
      check("start_on_release", 32'(ps2_data_oe), 32'd1);
    end
    prev_coe = ps2_clk_oe;
  end

  task automatic dev_run(input int mode);
    logic [10:0] obs;
    logic [10:0] e;
    int n;
    obs = '1;
    n = 0;
    while (ps2_clk_oe !== 1'b1 && n < 50) begin @(negedge clk_sys); n++; end
    n = 0;
    while (ps2_clk_oe !== 1'b0 && n < 500) begin @(negedge clk_sys); n++; end
    if (n >= 500) begin
      vectors++;
      misc++;
      $display("FAIL release_wait: clock still held after %0d cycles, required release", n);
      return;
    end
    repeat (HALF) @(negedge clk_sys);
    obs[0] = ps2_data_line;
    if (mode == M_NOCLK) return;
    for (int k = 1; k <= 10; k++) begin
      dev_clk_low = 1'b1;
      repeat (2*HALF) @(negedge clk_sys);
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk_sys);
      obs[k] = ps2_data_line;
      if (mode == M_RST && k == 4) break;
      repeat (HALF) @(negedge clk_sys);
    end
    if (exp_frame.size() == 0) begin
      vectors++;
      misc++;
      $display("FAIL frame_unexpected: got %03h expected none", obs);
    end else begin
      e = exp_frame.pop_front();
      if (mode == M_RST) check("frame_partial", 32'(obs[4:0]), 32'(e[4:0]));
      else               check("frame_bits", 32'(obs), 32'(e));
    end
    if (mode == M_RST) return;
    dev_data_low = (mode == M_ACK);
    repeat (10) @(negedge clk_sys);
    dev_clk_low = 1'b1;
    repeat (2*HALF) @(negedge clk_sys);
    dev_clk_low = 1'b0;
    repeat (10) @(negedge clk_sys);
    dev_data_low = 1'b0;
    repeat (5) @(negedge clk_sys);
  endtask

  task automatic issue(input logic [7:0] d);
    @(negedge clk_sys);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk_sys);
    check("accept", 32'({ps2_clk_oe, busy, tx_ready}), 32'b110);
  endtask

  task automatic wait_status(input int base);
    int n;
    n = 0;
    while (status_count <= base && n < 4000) begin @(negedge clk_sys); n++; end
    if (status_count <= base) begin
      vectors++;
      misc++;
      $display("FAIL status_wait: no done/error within %0d cycles", n);
    end
  endtask

  task automatic send(input logic [7:0] d, input int mode);
    int base;
    base = status_count;
    if (mode != M_NOCLK) exp_frame.push_back(model_frame(d));
    exp_status.push_back(mode == M_ACK ? ST_DONE : ST_ERR);
    issue(d);
    tx_valid = 1'b0;
    dev_run(mode);
    wait_status(base);
  endtask

  initial begin
    #(300000 * 1000);
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [7:0] d;
    reset = 1'b1;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    dev_clk_low = 1'b0;
    dev_data_low = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("reset_values", 32'({ps2_clk_oe, ps2_data_oe, tx_ready, busy, done, error}), 32'b001000);
    reset = 1'b0;
    repeat (5) @(negedge clk_sys);

    send(8'hED, M_ACK);
    send(8'h00, M_ACK);
    send(8'h01, M_ACK);
    send(8'hFF, M_ACK);
    send(8'hA5, M_NOACK);
    repeat (5) @(negedge clk_sys);

    send(8'h3C, M_NOCLK);
    repeat (2) @(negedge clk_sys);
    check("timeout_delay", 32'(stat_cyc - rel_cyc), 32'(TO_EXP));

    exp_frame.push_back(model_frame(8'h00));
    issue(8'h00);
    tx_valid = 1'b0;
    dev_run(M_RST);
    @(negedge clk_sys);
    check("pre_reset_data_oe", 32'(ps2_data_oe), 32'd1);
    #200;
    reset = 1'b1;
    #1;
    check("reset_async", 32'({ps2_clk_oe, ps2_data_oe, tx_ready, busy}), 32'b0010);
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    repeat (3) @(negedge clk_sys);
    send(8'hFF, M_ACK);

    base = status_count;
    exp_frame.push_back(model_frame(8'hF4));
    exp_status.push_back(ST_DONE);
    exp_frame.push_back(model_frame(8'hF5));
    exp_status.push_back(ST_DONE);
    issue(8'hF4);
    repeat (10) @(negedge clk_sys);
    tx_data = 8'hF5;
    dev_run(M_ACK);
    wait_status(base);
    repeat (3) @(negedge clk_sys);
    check("back_to_back", 32'(rise_cyc - stat_cyc), 32'd1);
    tx_valid = 1'b0;
    base = status_count;
    dev_run(M_ACK);
    wait_status(base);

    for (int i = 0; i < 14; i++) begin
      d = 8'($urandom_range(0, 255));
      send(d, ($urandom_range(0, 3) == 0) ? M_NOACK : M_ACK);
    end

    repeat (20) @(negedge clk_sys);
    check("queues_drained", 32'(exp_status.size() + exp_frame.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule
